// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm
//   Phase controller for a main/side two-road intersection with pedestrian
//   service, flashing-yellow maintenance mode and a phase-counter watchdog.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   g_end/y_end/r_end   phase-end pulses from the phase time counter
//   side_req            side-road vehicle sensor (level)
//   ped_req             pedestrian button (pulse or level)
//   flash_mode          maintenance flash request (level)
//   fsm_g/fsm_y/fsm_r   one-hot phase selects to the counter (all 0 in flash)
//   main_lamp/side_lamp {red, yellow, green} per road
//   ped_walk            walk lamp, high exactly while side green
//   fault               sticky watchdog / illegal-state fault
module traffic_phase_fsm #(
   parameter int unsigned FLASH_HALF = 8,
   parameter int unsigned WDOG_LIMIT = 300,
   parameter int unsigned WDOG_W     = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       g_end,
   input  logic       y_end,
   input  logic       r_end,
   input  logic       side_req,
   input  logic       ped_req,
   input  logic       flash_mode,
   output logic       fsm_g,
   output logic       fsm_y,
   output logic       fsm_r,
   output logic [2:0] main_lamp,
   output logic [2:0] side_lamp,
   output logic       ped_walk,
   output logic       fault
);

   localparam int unsigned DIV_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

   typedef enum logic [2:0] {
      MAIN_G = 3'd0,
      MAIN_Y = 3'd1,
      ALL_R1 = 3'd2,
      SIDE_G = 3'd3,
      SIDE_Y = 3'd4,
      ALL_R2 = 3'd5,
      FLASH  = 3'd6
   } state_t;

   state_t            state, state_nxt;
   logic              ped_pending, ped_pending_nxt;
   logic [WDOG_W-1:0] wdog, wdog_nxt;
   logic [DIV_W-1:0]  div, div_nxt;
   logic              blink, blink_nxt;
   logic              fault_nxt;
   logic              end_match;
   logic              timed;
   logic              illegal;
   logic              trip;

   always_comb begin
      end_match = 1'b0;
      timed     = 1'b1;
      illegal   = 1'b0;
      case (state)
         MAIN_G, SIDE_G: end_match = g_end;
         MAIN_Y, SIDE_Y: end_match = y_end;
         ALL_R1, ALL_R2: end_match = r_end;
         FLASH:          timed     = 1'b0;
         default: begin
            timed   = 1'b0;
            illegal = 1'b1;
         end
      endcase

      // Trips on the edge where the count would reach the limit.
      trip      = timed && !end_match && (wdog == WDOG_W'(WDOG_LIMIT - 1));
      fault_nxt = fault | trip | illegal;

      state_nxt = state;
      if (fault_nxt || flash_mode) begin
         state_nxt = FLASH;
      end else begin
         case (state)
            MAIN_G: if (g_end && (side_req || ped_pending)) state_nxt = MAIN_Y;
            MAIN_Y: if (y_end) state_nxt = ALL_R1;
            ALL_R1: if (r_end) state_nxt = SIDE_G;
            SIDE_G: if (g_end) state_nxt = SIDE_Y;
            SIDE_Y: if (y_end) state_nxt = ALL_R2;
            ALL_R2: if (r_end) state_nxt = MAIN_G;
            FLASH:  state_nxt = ALL_R2;
            default: state_nxt = FLASH;
         endcase
      end

      if ((state_nxt != state) || end_match || (state_nxt == FLASH)) begin
         wdog_nxt = '0;
      end else begin
         wdog_nxt = wdog + WDOG_W'(1);
      end

      ped_pending_nxt = ped_pending | (ped_req && (state != SIDE_G));
      if ((state_nxt == SIDE_G) && (state != SIDE_G)) begin
         ped_pending_nxt = 1'b0;
      end

      div_nxt   = '0;
      blink_nxt = 1'b0;
      if (state_nxt == FLASH) begin
         if (state != FLASH) begin
            blink_nxt = 1'b1;
         end else if (div == DIV_W'(FLASH_HALF - 1)) begin
            blink_nxt = ~blink;
         end else begin
            div_nxt   = div + DIV_W'(1);
            blink_nxt = blink;
         end
      end
   end

   // Outputs are registered from the next-state values so they line up with
   // the state register while staying free of input-to-output paths.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ALL_R2;
         ped_pending <= 1'b0;
         wdog        <= '0;
         div         <= '0;
         blink       <= 1'b0;
         fault       <= 1'b0;
         fsm_g       <= 1'b0;
         fsm_y       <= 1'b0;
         fsm_r       <= 1'b1;
         main_lamp   <= 3'b100;
         side_lamp   <= 3'b100;
         ped_walk    <= 1'b0;
      end else begin
         state       <= state_nxt;
         ped_pending <= ped_pending_nxt;
         wdog        <= wdog_nxt;
         div         <= div_nxt;
         blink       <= blink_nxt;
         fault       <= fault_nxt;
         fsm_g       <= (state_nxt == MAIN_G) || (state_nxt == SIDE_G);
         fsm_y       <= (state_nxt == MAIN_Y) || (state_nxt == SIDE_Y);
         fsm_r       <= (state_nxt == ALL_R1) || (state_nxt == ALL_R2);
         ped_walk    <= (state_nxt == SIDE_G);
         case (state_nxt)
            MAIN_G: begin
               main_lamp <= 3'b001;
               side_lamp <= 3'b100;
            end
            MAIN_Y: begin
               main_lamp <= 3'b010;
               side_lamp <= 3'b100;
            end
            SIDE_G: begin
               main_lamp <= 3'b100;
               side_lamp <= 3'b001;
            end
            SIDE_Y: begin
               main_lamp <= 3'b100;
               side_lamp <= 3'b010;
            end
            FLASH: begin
               main_lamp <= {1'b0, blink_nxt, 1'b0};
               side_lamp <= {1'b0, blink_nxt, 1'b0};
            end
            default: begin
               main_lamp <= 3'b100;
               side_lamp <= 3'b100;
            end
         endcase
      end
   end

endmodule
